vend_sequencer: RTL and testbench



---
 rtl/vend_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_vend_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/vend_sequencer.sv
// Vending machine controller: coin credit, fixed-priority product select,
// timed dispense strobe and coin-by-coin change payout.
module vend_sequencer #(
  parameter int PRICE           = 75,
  parameter int MAX_CREDIT      = 100,
  parameter int DISPENSE_CYCLES = 4,
  parameter int CHANGE_GAP      = 2
) (
  input  logic       clock_50MHz,
  input  logic       async_Reset,
  input  logic [2:0] coin_in,
  input  logic [3:0] select_in,
  input  logic       cancel_in,
  output logic [3:0] dispense_out,
  output logic [2:0] change_out,
  output logic       coin_reject,
  output logic       insufficient,
  output logic [7:0] credit,
  output logic [1:0] state_out,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CREDIT   = 2'd1,
    S_DISPENSE = 2'd2,
    S_CHANGE   = 2'd3
  } state_e;

  localparam int DCW = $clog2(DISPENSE_CYCLES) + 1;
  localparam int GCW = $clog2(CHANGE_GAP) + 1;
  localparam logic [DCW-1:0] DISP_LAST = DCW'(DISPENSE_CYCLES - 1);
  localparam logic [GCW-1:0] GAP_LAST  = GCW'(CHANGE_GAP - 1);
  localparam logic [8:0]     MAX9      = 9'(MAX_CREDIT);
  localparam logic [7:0]     PRICE8    = 8'(PRICE);

  function automatic logic [7:0] coin_value(input logic [2:0] c);
    case (c)
      3'b001:  coin_value = 8'd5;
      3'b010:  coin_value = 8'd10;
      3'b100:  coin_value = 8'd25;
      default: coin_value = 8'd0;
    endcase
  endfunction

  // Greedy payout: largest coin that does not exceed the remaining credit.
  function automatic logic [2:0] change_coin(input logic [7:0] cr);
    if (cr >= 8'd25)      change_coin = 3'b100;
    else if (cr >= 8'd10) change_coin = 3'b010;
    else if (cr >= 8'd5)  change_coin = 3'b001;
    else                  change_coin = 3'b000;
  endfunction

  function automatic logic [3:0] lowest_set(input logic [3:0] s);
    lowest_set = s & (~s + 4'd1);
  endfunction

  state_e         state_q, state_d;
  logic [7:0]     credit_q, credit_d;
  logic [3:0]     dispense_q, dispense_d;
  logic [2:0]     change_q, change_d;
  logic           reject_q, reject_d;
  logic           insuff_q, insuff_d;
  logic [DCW-1:0] disp_cnt_q, disp_cnt_d;
  logic [GCW-1:0] gap_cnt_q, gap_cnt_d;

  logic       coin_any, coin_onehot, coin_ok, sel_any, can_buy;
  logic [8:0] coin_sum;
  logic [2:0] pay_coin;

  assign coin_any    = (coin_in != 3'b000);
  assign coin_onehot = coin_any && ((coin_in & (coin_in - 3'd1)) == 3'b000);
  assign coin_sum    = {1'b0, credit_q} + {1'b0, coin_value(coin_in)};
  assign coin_ok     = coin_onehot && (coin_sum <= MAX9);
  assign sel_any     = (select_in != 4'b0000);
  assign can_buy     = (credit_q >= PRICE8);
  assign pay_coin    = change_coin(credit_q);

  always_ff @(posedge clock_50MHz or negedge async_Reset) begin
    if (!async_Reset) begin
      state_q    <= S_IDLE;
      credit_q   <= 8'd0;
      dispense_q <= 4'b0000;
      change_q   <= 3'b000;
      reject_q   <= 1'b0;
      insuff_q   <= 1'b0;
      disp_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      dispense_q <= dispense_d;
      change_q   <= change_d;
      reject_q   <= reject_d;
      insuff_q   <= insuff_d;
      disp_cnt_q <= disp_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (coin_ok) state_d = S_CREDIT;
      S_CREDIT: begin
        if (cancel_in)                state_d = S_CHANGE;
        else if (sel_any && can_buy)  state_d = S_DISPENSE;
      end
      S_DISPENSE: begin
        if (disp_cnt_q == '0) state_d = (credit_q != 8'd0) ? S_CHANGE : S_IDLE;
      end
      S_CHANGE: if (credit_q == 8'd0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    credit_d   = credit_q;
    dispense_d = dispense_q;
    change_d   = 3'b000;
    reject_d   = 1'b0;
    insuff_d   = 1'b0;
    disp_cnt_d = disp_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (coin_ok)       credit_d = coin_sum[7:0];
        else if (coin_any) reject_d = 1'b1;
      end
      S_CREDIT: begin
        // Cancel and select outrank a coin offered in the same cycle.
        if (cancel_in) begin
          reject_d  = coin_any;
          gap_cnt_d = '0;
        end else if (sel_any) begin
          reject_d = coin_any;
          if (can_buy) begin
            credit_d   = credit_q - PRICE8;
            dispense_d = lowest_set(select_in);
            disp_cnt_d = DISP_LAST;
          end else begin
            insuff_d = 1'b1;
          end
        end else if (coin_ok) begin
          credit_d = coin_sum[7:0];
        end else if (coin_any) begin
          reject_d = 1'b1;
        end
      end
      S_DISPENSE: begin
        reject_d = coin_any;
        if (disp_cnt_q == '0) begin
          dispense_d = 4'b0000;
          gap_cnt_d  = '0;
        end else begin
          disp_cnt_d = disp_cnt_q - DCW'(1);
        end
      end
      S_CHANGE: begin
        reject_d = coin_any;
        if (credit_q != 8'd0) begin
          if (gap_cnt_q == '0) begin
            change_d  = pay_coin;
            credit_d  = credit_q - coin_value(pay_coin);
            gap_cnt_d = GAP_LAST;
          end else begin
            gap_cnt_d = gap_cnt_q - GCW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  assign dispense_out = dispense_q;
  assign change_out   = change_q;
  assign coin_reject  = reject_q;
  assign insufficient = insuff_q;
  assign credit       = credit_q;
  assign state_out    = state_q;
  assign busy         = state_q[1];

endmodule

// File: tb/tb_vend_sequencer.sv
// Table-driven scoreboard bench for vend_sequencer: each record is one cycle of
// stimulus plus the outputs expected after the following rising edge.
module tb_vend_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] coin_in;
  logic [3:0] select_in;
  logic       cancel_in;
  logic [3:0] dispense_out;
  logic [2:0] change_out;
  logic       coin_reject;
  logic       insufficient;
  logic [7:0] credit;
  logic [1:0] state_out;
  logic       busy;

  vend_sequencer dut (
    .clock_50MHz (clk),
    .async_Reset (rst_n),
    .coin_in     (coin_in),
    .select_in   (select_in),
    .cancel_in   (cancel_in),
    .dispense_out(dispense_out),
    .change_out  (change_out),
    .coin_reject (coin_reject),
    .insufficient(insufficient),
    .credit      (credit),
    .state_out   (state_out),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] coin;
    logic [3:0] sel;
    logic       cancel;
    logic [3:0] disp;
    logic [2:0] chg;
    logic       rej;
    logic       ins;
    logic [7:0] cr;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void V(input logic [2:0] coin, input logic [3:0] sel, input logic cancel,
                            input logic [3:0] disp, input logic [2:0] chg, input logic rej,
                            input logic ins, input logic [7:0] cr, input logic [1:0] st);
    vec_t v;
    v.coin = coin; v.sel = sel; v.cancel = cancel;
    v.disp = disp; v.chg = chg; v.rej = rej; v.ins = ins; v.cr = cr; v.st = st;
    vecs.push_back(v);
  endfunction

  function automatic void idle(input int n, input logic [3:0] disp, input logic [7:0] cr,
                               input logic [1:0] st);
    for (int i = 0; i < n; i++) V(3'd0, 4'd0, 1'b0, disp, 3'd0, 1'b0, 1'b0, cr, st);
  endfunction

  task automatic apply(input vec_t v, input string name);
    vec_t e;
    coin_in   = v.coin;
    select_in = v.sel;
    cancel_in = v.cancel;
    sb.push_back(v);
    @(posedge clk);
    #1;
    coin_in   = 3'd0;
    select_in = 4'd0;
    cancel_in = 1'b0;
    e = sb.pop_front();
    n_vec++;
    if (dispense_out !== e.disp || change_out !== e.chg || coin_reject !== e.rej ||
        insufficient !== e.ins || credit !== e.cr || state_out !== e.st || busy !== e.st[1]) begin
      n_bad++;
      $display("FAIL %s: got disp=%b chg=%b rej=%b ins=%b cr=%0d st=%0d busy=%b, want disp=%b chg=%b rej=%b ins=%b cr=%0d st=%0d busy=%b",
               name, dispense_out, change_out, coin_reject, insufficient, credit, state_out, busy,
               e.disp, e.chg, e.rej, e.ins, e.cr, e.st, e.st[1]);
    end
  endtask

  task automatic check_reset_zero(input string name);
    n_vec++;
    if ({dispense_out, change_out, coin_reject, insufficient, credit, state_out, busy} !== 21'd0) begin
      n_bad++;
      $display("FAIL %s: got disp=%b chg=%b rej=%b ins=%b cr=%0d st=%0d busy=%b, want all zero",
               name, dispense_out, change_out, coin_reject, insufficient, credit, state_out, busy);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    coin_in   = 3'd0;
    select_in = 4'd0;
    cancel_in = 1'b0;

    // IDLE corner cases
    idle(1, 4'd0, 8'd0, 2'd0);
    V(3'd0, 4'b0001, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 8'd0, 2'd0);
    V(3'b111, 4'd0, 1'b0, 4'd0, 3'd0, 1'b1, 1'b0, 8'd0, 2'd0);
    V(3'd0, 4'd0, 1'b1, 4'd0, 3'd0, 1'b0, 1'b0, 8'd0, 2'd0);
    // Exact price, no change
    V(3'b100, 4'd0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 8'd25, 2'd1);
    V(3'b100, 4'd0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 8'd50, 2'd1);
    V(3'b100, 4'd0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 8'd75, 2'd1);
    V(3'd0, 4'b0100, 1'b0, 4'b0100, 3'd0, 1'b0, 1'b0, 8'd0, 2'd2);
    idle(3, 4'b0100, 8'd0, 2'd2);
    idle(2, 4'd0, 8'd0, 2'd0);
    // Ceiling reject, arbitration, one-coin change
    V(3'b100, 4'd0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 8'd25, 2'd1);
    V(3'b100, 4'd0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 8'd50, 2'd1);
    V(3'b100, 4'd0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 8'd75, 2'd1);
    V(3'b100, 4'd0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 8'd100, 2'd1);
    V(3'b001, 4'd0, 1'b0, 4'd0, 3'd0, 1'b1, 1'b0, 8'd100, 2'd1);
    V(3'd0, 4'b0011, 1'b0, 4'b0001, 3'd0, 1'b0, 1'b0, 8'd25, 2'd2);
    idle(3, 4'b0001, 8'd25, 2'd2);
    idle(1, 4'd0, 8'd25, 2'd3);
    V(3'd0, 4'd0, 1'b0, 4'd0, 3'b100, 1'b0, 1'b0, 8'd0, 2'd3);
    idle(1, 4'd0, 8'd0, 2'd0);
    // Cancel with 40c: 25, 10, 5 two cycles apart
    V(3'b100, 4'd0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 8'd25, 2'd1);
    V(3'b010, 4'd0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 8'd35, 2'd1);
    V(3'b001, 4'd0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 8'd40, 2'd1);
    V(3'd0, 4'd0, 1'b1, 4'd0, 3'd0, 1'b0, 1'b0, 8'd40, 2'd3);
    V(3'd0, 4'd0, 1'b0, 4'd0, 3'b100, 1'b0, 1'b0, 8'd15, 2'd3);
    idle(1, 4'd0, 8'd15, 2'd3);
    V(3'd0, 4'd0, 1'b0, 4'd0, 3'b010, 1'b0, 1'b0, 8'd5, 2'd3);
    idle(1, 4'd0, 8'd5, 2'd3);
    V(3'd0, 4'd0, 1'b0, 4'd0, 3'b001, 1'b0, 1'b0, 8'd0, 2'd3);
    idle(1, 4'd0, 8'd0, 2'd0);
    // Insufficient credit and multi-coin reject in CREDIT
    V(3'b100, 4'd0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 8'd25, 2'd1);
    V(3'b100, 4'd0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 8'd50, 2'd1);
    V(3'd0, 4'b1000, 1'b0, 4'd0, 3'd0, 1'b0, 1'b1, 8'd50, 2'd1);
    V(3'b011, 4'd0, 1'b0, 4'd0, 3'd0, 1'b1, 1'b0, 8'd50, 2'd1);
    V(3'd0, 4'd0, 1'b1, 4'd0, 3'd0, 1'b0, 1'b0, 8'd50, 2'd3);
    V(3'd0, 4'd0, 1'b0, 4'd0, 3'b100, 1'b0, 1'b0, 8'd25, 2'd3);
    idle(1, 4'd0, 8'd25, 2'd3);
    V(3'd0, 4'd0, 1'b0, 4'd0, 3'b100, 1'b0, 1'b0, 8'd0, 2'd3);
    idle(1, 4'd0, 8'd0, 2'd0);
    // Cancel+select+coin together, coins while busy
    V(3'b100, 4'd0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 8'd25, 2'd1);
    V(3'b100, 4'd0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 8'd50, 2'd1);
    V(3'b100, 4'd0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 8'd75, 2'd1);
    V(3'b100, 4'b0001, 1'b1, 4'd0, 3'd0, 1'b1, 1'b0, 8'd75, 2'd3);
    V(3'd0, 4'd0, 1'b0, 4'd0, 3'b100, 1'b0, 1'b0, 8'd50, 2'd3);
    V(3'b001, 4'd0, 1'b0, 4'd0, 3'd0, 1'b1, 1'b0, 8'd50, 2'd3);
    V(3'd0, 4'd0, 1'b0, 4'd0, 3'b100, 1'b0, 1'b0, 8'd25, 2'd3);
    idle(1, 4'd0, 8'd25, 2'd3);
    V(3'd0, 4'd0, 1'b0, 4'd0, 3'b100, 1'b0, 1'b0, 8'd0, 2'd3);
    idle(1, 4'd0, 8'd0, 2'd0);
    V(3'b100, 4'd0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 8'd25, 2'd1);
    V(3'b100, 4'd0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 8'd50, 2'd1);
    V(3'b100, 4'd0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 8'd75, 2'd1);
    V(3'd0, 4'b0001, 1'b0, 4'b0001, 3'd0, 1'b0, 1'b0, 8'd0, 2'd2);
    V(3'b100, 4'd0, 1'b0, 4'b0001, 3'd0, 1'b1, 1'b0, 8'd0, 2'd2);
    idle(2, 4'b0001, 8'd0, 2'd2);
    idle(1, 4'd0, 8'd0, 2'd0);

    #12;
    check_reset_zero("reset_initial");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Reset arriving mid-CHANGE with 15c of credit
    begin
      vec_t r;
      r = '{coin:3'b010, sel:4'd0, cancel:1'b0, disp:4'd0, chg:3'd0, rej:1'b0, ins:1'b0, cr:8'd10, st:2'd1};
      apply(r, "rst_seq_coin10");
      r = '{coin:3'b001, sel:4'd0, cancel:1'b0, disp:4'd0, chg:3'd0, rej:1'b0, ins:1'b0, cr:8'd15, st:2'd1};
      apply(r, "rst_seq_coin5");
      r = '{coin:3'd0, sel:4'd0, cancel:1'b1, disp:4'd0, chg:3'd0, rej:1'b0, ins:1'b0, cr:8'd15, st:2'd3};
      apply(r, "rst_seq_cancel");
      r = '{coin:3'd0, sel:4'd0, cancel:1'b0, disp:4'd0, chg:3'b010, rej:1'b0, ins:1'b0, cr:8'd5, st:2'd3};
      apply(r, "rst_seq_pay10");
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_zero("reset_async_immediate");
      @(posedge clk);
      #1;
      check_reset_zero("reset_held");
      @(negedge clk);
      rst_n = 1'b1;
      r = '{coin:3'd0, sel:4'd0, cancel:1'b0, disp:4'd0, chg:3'd0, rej:1'b0, ins:1'b0, cr:8'd0, st:2'd0};
      apply(r, "post_reset_idle");
      r = '{coin:3'b100, sel:4'd0, cancel:1'b0, disp:4'd0, chg:3'd0, rej:1'b0, ins:1'b0, cr:8'd25, st:2'd1};
      apply(r, "post_reset_coin");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
